// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch/writeback inputs and the registered execute bundle
// of the RV32I decode stage, grouped as one bus. The stage itself connects
// through the slave modport; the fetch/execute side (or a bench) uses master.
interface decode_stage_if #(parameter int XLEN = 32);
   logic [31:0]     InstrD;
   logic [XLEN-1:0] PC_DE;
   logic            PC_R;
   logic            WE_W;
   logic [4:0]      RD_W;
   logic [XLEN-1:0] WD_W;
   logic            VALID_E;
   logic [XLEN-1:0] PC_E;
   logic [XLEN-1:0] RS1_E;
   logic [XLEN-1:0] RS2_E;
   logic [XLEN-1:0] IMM_E;
   logic [4:0]      RD_E;
   logic [3:0]      ALU_OP_E;
   logic            ALU_A_PC_E;
   logic            ALU_B_IMM_E;
   logic            REG_WE_E;
   logic            MEM_RE_E;
   logic            MEM_WE_E;
   logic            BR_E;
   logic [2:0]      FUNCT3_E;
   logic [1:0]      JMP_E;
   logic            ILLEGAL_E;

   modport master (
      output InstrD, PC_DE, PC_R, WE_W, RD_W, WD_W,
      input  VALID_E, PC_E, RS1_E, RS2_E, IMM_E, RD_E, ALU_OP_E, ALU_A_PC_E,
             ALU_B_IMM_E, REG_WE_E, MEM_RE_E, MEM_WE_E, BR_E, FUNCT3_E,
             JMP_E, ILLEGAL_E
   );

   modport slave (
      input  InstrD, PC_DE, PC_R, WE_W, RD_W, WD_W,
      output VALID_E, PC_E, RS1_E, RS2_E, IMM_E, RD_E, ALU_OP_E, ALU_A_PC_E,
             ALU_B_IMM_E, REG_WE_E, MEM_RE_E, MEM_WE_E, BR_E, FUNCT3_E,
             JMP_E, ILLEGAL_E
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage. Decodes the fetched instruction, reads
// the 32x32 register file (written from writeback) and registers the execute
// bundle with one cycle of latency. A redirect from execute squashes the
// sampled instruction plus SQUASH_DEPTH-1 following ones.
// Optional build macro DECODE_WB_BYPASS_EN: a writeback in the same cycle as
// the operand read is forwarded into RS1_E/RS2_E (write-first).
module decode_stage #(
   parameter int XLEN         = 32,
   parameter int SQUASH_DEPTH = 2
) (
   input logic            clk,
   input logic            rst,
   decode_stage_if.slave  bus
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] SQ_RELOAD = 2'(SQUASH_DEPTH - 1);

   // funct3 to ALU op; alt selects SUB/SRA on the 000/101 encodings
   function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return 4'd2;
         3'b010:  return 4'd3;
         3'b011:  return 4'd4;
         3'b100:  return 4'd5;
         3'b101:  return alt ? 4'd7 : 4'd6;
         3'b110:  return 4'd8;
         default: return 4'd9;
      endcase
   endfunction

   logic [XLEN-1:0] regs [32];
   logic [1:0]      sq;

   logic [31:0]     instr;
   logic [6:0]      opc;
   logic [6:0]      f7;
   logic [2:0]      f3;
   logic [4:0]      rs1_a;
   logic [4:0]      rs2_a;
   logic [4:0]      rd_a;

   logic [XLEN-1:0] d_imm;
   logic [3:0]      d_op;
   logic            d_apc;
   logic            d_bimm;
   logic            d_rwe;
   logic            d_mre;
   logic            d_mwe;
   logic            d_br;
   logic [1:0]      d_jmp;
   logic            d_ill;

   logic [XLEN-1:0] rs1_v;
   logic [XLEN-1:0] rs2_v;
   logic            bubble;

   assign instr = bus.InstrD;
   assign opc   = instr[6:0];
   assign rd_a  = instr[11:7];
   assign f3    = instr[14:12];
   assign rs1_a = instr[19:15];
   assign rs2_a = instr[24:20];
   assign f7    = instr[31:25];

   // a redirect (or its trailing window) or an all-zero word yields a bubble
   assign bubble = bus.PC_R || (sq != 2'd0) || (instr == 32'h0);

   // opcode decode into immediate, ALU controls and enables
   always_comb begin
      d_imm  = '0;
      d_op   = ALU_ADD;
      d_apc  = 1'b0;
      d_bimm = 1'b0;
      d_rwe  = 1'b0;
      d_mre  = 1'b0;
      d_mwe  = 1'b0;
      d_br   = 1'b0;
      d_jmp  = 2'd0;
      d_ill  = 1'b0;
      case (opc)
         OPC_LUI: begin
            d_imm  = {instr[31:12], 12'h0};
            d_op   = ALU_PASSB;
            d_bimm = 1'b1;
            d_rwe  = 1'b1;
         end
         OPC_AUIPC: begin
            d_imm  = {instr[31:12], 12'h0};
            d_apc  = 1'b1;
            d_bimm = 1'b1;
            d_rwe  = 1'b1;
         end
         OPC_JAL: begin
            d_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            d_apc  = 1'b1;
            d_bimm = 1'b1;
            d_rwe  = 1'b1;
            d_jmp  = 2'd1;
         end
         OPC_JALR: begin
            d_imm  = {{20{instr[31]}}, instr[31:20]};
            d_bimm = 1'b1;
            d_rwe  = 1'b1;
            d_jmp  = 2'd2;
         end
         OPC_BRANCH: begin
            d_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            d_op   = ALU_SUB;
            d_br   = 1'b1;
         end
         OPC_LOAD: begin
            d_imm  = {{20{instr[31]}}, instr[31:20]};
            d_bimm = 1'b1;
            d_mre  = 1'b1;
            d_rwe  = 1'b1;
         end
         OPC_STORE: begin
            d_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            d_bimm = 1'b1;
            d_mwe  = 1'b1;
         end
         OPC_OPIMM: begin
            d_imm  = {{20{instr[31]}}, instr[31:20]};
            d_op   = alu_sel(f3, (f3 == 3'b101) && instr[30]);
            d_bimm = 1'b1;
            d_rwe  = 1'b1;
         end
         OPC_OP: begin
            d_op  = alu_sel(f3, f7[5]);
            d_rwe = 1'b1;
            // only 0000000, or 0100000 on ADD/SRL encodings, are base-ISA OPs
            if (!((f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))))
               d_ill = 1'b1;
         end
         default: d_ill = 1'b1;
      endcase
      if (d_ill) begin
         d_rwe = 1'b0;
         d_mre = 1'b0;
         d_mwe = 1'b0;
         d_br  = 1'b0;
         d_jmp = 2'd0;
      end
      if (rd_a == 5'd0)
         d_rwe = 1'b0;
   end

   // register file read ports, x0 hardwired to zero
   always_comb begin
      rs1_v = (rs1_a == 5'd0) ? '0 : regs[rs1_a];
      rs2_v = (rs2_a == 5'd0) ? '0 : regs[rs2_a];
`ifdef DECODE_WB_BYPASS_EN
      if (bus.WE_W && (bus.RD_W != 5'd0) && (bus.RD_W == rs1_a))
         rs1_v = bus.WD_W;
      if (bus.WE_W && (bus.RD_W != 5'd0) && (bus.RD_W == rs2_a))
         rs2_v = bus.WD_W;
`endif
   end

   // register file write port; reset clears every entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 32; k++)
            regs[k] <= '0;
      end else if (bus.WE_W && (bus.RD_W != 5'd0)) begin
         regs[bus.RD_W] <= bus.WD_W;
      end
   end

   // squash window counter; a new redirect reloads rather than extends it
   always_ff @(posedge clk) begin
      if (rst)
         sq <= 2'd0;
      else if (bus.PC_R)
         sq <= SQ_RELOAD;
      else if (sq != 2'd0)
         sq <= sq - 2'd1;
   end

   // execute bundle register; bubbles clear every field
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         bus.VALID_E     <= 1'b0;
         bus.PC_E        <= '0;
         bus.RS1_E       <= '0;
         bus.RS2_E       <= '0;
         bus.IMM_E       <= '0;
         bus.RD_E        <= '0;
         bus.ALU_OP_E    <= '0;
         bus.ALU_A_PC_E  <= 1'b0;
         bus.ALU_B_IMM_E <= 1'b0;
         bus.REG_WE_E    <= 1'b0;
         bus.MEM_RE_E    <= 1'b0;
         bus.MEM_WE_E    <= 1'b0;
         bus.BR_E        <= 1'b0;
         bus.FUNCT3_E    <= '0;
         bus.JMP_E       <= '0;
         bus.ILLEGAL_E   <= 1'b0;
      end else begin
         bus.VALID_E     <= 1'b1;
         bus.PC_E        <= bus.PC_DE;
         bus.RS1_E       <= rs1_v;
         bus.RS2_E       <= rs2_v;
         bus.IMM_E       <= d_imm;
         bus.RD_E        <= rd_a;
         bus.ALU_OP_E    <= d_op;
         bus.ALU_A_PC_E  <= d_apc;
         bus.ALU_B_IMM_E <= d_bimm;
         bus.REG_WE_E    <= d_rwe;
         bus.MEM_RE_E    <= d_mre;
         bus.MEM_WE_E    <= d_mwe;
         bus.BR_E        <= d_br;
         bus.FUNCT3_E    <= f3;
         bus.JMP_E       <= d_jmp;
         bus.ILLEGAL_E   <= d_ill;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage. The stimulus process
// pushes the hand-computed execute bundle for every issued cycle; a monitor
// pops one entry after each rising edge and compares the masked fields.
module tb_decode_stage;

   localparam int F_VALID = 0, F_PC = 1, F_RS1 = 2, F_RS2 = 3, F_IMM = 4, F_RD = 5,
                  F_OP = 6, F_APC = 7, F_BIMM = 8, F_RWE = 9, F_MRE = 10,
                  F_MWE = 11, F_BR = 12, F_F3 = 13, F_JMP = 14, F_ILL = 15;
   localparam logic [15:0] ALL = 16'hFFFF;
   localparam logic [15:0] CTL = 16'h0001 | 16'h0200 | 16'h0400 | 16'h0800 |
                                 16'h1000 | 16'h4000 | 16'h8000;

   typedef struct {
      int          id;
      logic [15:0] m;
      logic        valid;
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic [3:0]  op;
      logic        apc, bimm, rwe, mre, mwe, br;
      logic [2:0]  f3;
      logic [1:0]  jmp;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t q[$];
   exp_t cur;
   int   vectors = 0;
   int   miscompares = 0;
   int   next_id = 0;

   decode_stage_if bus ();

   decode_stage #(.XLEN(32), .SQUASH_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [15:0] m);
      exp_t e;
      e.id = 0; e.m = m; e.valid = 1'b0; e.pc = '0; e.rs1 = '0; e.rs2 = '0;
      e.imm = '0; e.rd = '0; e.op = '0; e.apc = 1'b0; e.bimm = 1'b0;
      e.rwe = 1'b0; e.mre = 1'b0; e.mwe = 1'b0; e.br = 1'b0; e.f3 = '0;
      e.jmp = '0; e.ill = 1'b0;
      return e;
   endfunction

   // valid instruction with the common fields filled in
   function automatic exp_t vi(input logic [15:0] m, input logic [31:0] pc,
                               input logic [4:0] rd, input logic [3:0] op,
                               input logic [31:0] imm, input logic [2:0] f3,
                               input logic bimm, input logic rwe);
      exp_t e;
      e = mk(m);
      e.valid = 1'b1; e.pc = pc; e.rd = rd; e.op = op; e.imm = imm;
      e.f3 = f3; e.bimm = bimm; e.rwe = rwe;
      return e;
   endfunction

   // addi x1,x0,5
   function automatic exp_t addi_exp(input logic [31:0] pc);
      return vi(ALL, pc, 5'd1, 4'd0, 32'd5, 3'd0, 1'b1, 1'b1);
   endfunction

   task automatic issue(input logic r, input logic [31:0] instr, input logic [31:0] pc,
                        input logic pcr, input logic we, input logic [4:0] rdw,
                        input logic [31:0] wdw, input exp_t e);
      exp_t t;
      @(negedge clk);
      rst = r;
      bus.InstrD = instr; bus.PC_DE = pc; bus.PC_R = pcr;
      bus.WE_W = we; bus.RD_W = rdw; bus.WD_W = wdw;
      t = e;
      t.id = next_id;
      next_id++;
      q.push_back(t);
   endtask

   task automatic run(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
      issue(1'b0, instr, pc, 1'b0, 1'b0, 5'd0, 32'h0, e);
   endtask

   task automatic cmp(input int id, input string f, input logic [31:0] act,
                      input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL vec%0d %s actual=%08h required=%08h", id, f, act, req);
      end
   endtask

   task automatic check(input exp_t e);
      if (e.m[F_VALID]) cmp(e.id, "VALID_E",     32'(bus.VALID_E),     32'(e.valid));
      if (e.m[F_PC])    cmp(e.id, "PC_E",        bus.PC_E,             e.pc);
      if (e.m[F_RS1])   cmp(e.id, "RS1_E",       bus.RS1_E,            e.rs1);
      if (e.m[F_RS2])   cmp(e.id, "RS2_E",       bus.RS2_E,            e.rs2);
      if (e.m[F_IMM])   cmp(e.id, "IMM_E",       bus.IMM_E,            e.imm);
      if (e.m[F_RD])    cmp(e.id, "RD_E",        32'(bus.RD_E),        32'(e.rd));
      if (e.m[F_OP])    cmp(e.id, "ALU_OP_E",    32'(bus.ALU_OP_E),    32'(e.op));
      if (e.m[F_APC])   cmp(e.id, "ALU_A_PC_E",  32'(bus.ALU_A_PC_E),  32'(e.apc));
      if (e.m[F_BIMM])  cmp(e.id, "ALU_B_IMM_E", 32'(bus.ALU_B_IMM_E), 32'(e.bimm));
      if (e.m[F_RWE])   cmp(e.id, "REG_WE_E",    32'(bus.REG_WE_E),    32'(e.rwe));
      if (e.m[F_MRE])   cmp(e.id, "MEM_RE_E",    32'(bus.MEM_RE_E),    32'(e.mre));
      if (e.m[F_MWE])   cmp(e.id, "MEM_WE_E",    32'(bus.MEM_WE_E),    32'(e.mwe));
      if (e.m[F_BR])    cmp(e.id, "BR_E",        32'(bus.BR_E),        32'(e.br));
      if (e.m[F_F3])    cmp(e.id, "FUNCT3_E",    32'(bus.FUNCT3_E),    32'(e.f3));
      if (e.m[F_JMP])   cmp(e.id, "JMP_E",       32'(bus.JMP_E),       32'(e.jmp));
      if (e.m[F_ILL])   cmp(e.id, "ILLEGAL_E",   32'(bus.ILLEGAL_E),   32'(e.ill));
   endtask

   // monitor: one expected bundle per issued cycle, checked just after the edge
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         cur = q.pop_front();
         vectors++;
         check(cur);
      end
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      logic [31:0] ins;
      logic [31:0] rs2_same;
      rst = 1'b1;
      bus.InstrD = 32'h00500093; bus.PC_DE = 32'h10; bus.PC_R = 1'b0;
      bus.WE_W = 1'b0; bus.RD_W = 5'd0; bus.WD_W = 32'h0;

      // reset flush; the write to x4 during reset must lose to rst
      issue(1'b1, 32'h00500093, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0, mk(ALL));
      issue(1'b1, 32'h00500093, 32'h10, 1'b1, 1'b1, 5'd4, 32'h55, mk(ALL));

      // all registers read zero after reset: add x5, xk, xk+1
      for (int k = 1; k < 32; k += 2) begin
         ins = {7'b0, 5'((k + 1) % 32), 5'(k), 3'b000, 5'd5, 7'b0110011};
         e = vi(ALL & ~(16'h1 << F_IMM), 32'h100 + 32'(4 * k), 5'd5, 4'd0, 32'h0,
                3'd0, 1'b0, 1'b1);
         run(ins, 32'h100 + 32'(4 * k), e);
      end

      // addi x1,x0,5
      run(32'h00500093, 32'h10, addi_exp(32'h10));

      // beq x0,x0,-4
      e = vi(ALL & ~((16'h1 << F_RD) | (16'h1 << F_OP) | (16'h1 << F_BIMM)),
             32'h14, 5'd0, 4'd0, 32'hFFFFFFFC, 3'd0, 1'b0, 1'b0);
      e.br = 1'b1;
      run(32'hFE000EE3, 32'h14, e);

      // jal x1,-1MiB
      e = vi(ALL & ~((16'h1 << F_OP) | (16'h1 << F_BIMM) | (16'h1 << F_RS1) |
                     (16'h1 << F_RS2) | (16'h1 << F_F3)),
             32'h18, 5'd1, 4'd0, 32'hFFF00000, 3'd0, 1'b0, 1'b1);
      e.apc = 1'b1; e.jmp = 2'd1;
      run(32'h800000EF, 32'h18, e);

      // writeback x3 in the same cycle as add x1,x2,x3, then the next cycle
`ifdef DECODE_WB_BYPASS_EN
      rs2_same = 32'hDEADBEEF;
`else
      rs2_same = 32'h0;
`endif
      e = vi(ALL & ~(16'h1 << F_IMM), 32'h1C, 5'd1, 4'd0, 32'h0, 3'd0, 1'b0, 1'b1);
      e.rs2 = rs2_same;
      issue(1'b0, 32'h003100B3, 32'h1C, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, e);
      e.pc = 32'h20; e.rs2 = 32'hDEADBEEF;
      run(32'h003100B3, 32'h20, e);

      // sub x1,x2,x3
      e = vi(ALL & ~(16'h1 << F_IMM), 32'h24, 5'd1, 4'd1, 32'h0, 3'd0, 1'b0, 1'b1);
      e.rs2 = 32'hDEADBEEF;
      run(32'h403100B3, 32'h24, e);

      // srai x1,x2,3
      run(32'h40315093, 32'h28,
          vi(ALL & ~(16'h1 << F_RS2), 32'h28, 5'd1, 4'd7, 32'h403, 3'd5, 1'b1, 1'b1));

      // lui x1,0x12345
      run(32'h123450B7, 32'h2C,
          vi(ALL & ~((16'h1 << F_RS1) | (16'h1 << F_RS2) | (16'h1 << F_F3)),
             32'h2C, 5'd1, 4'd10, 32'h12345000, 3'd0, 1'b1, 1'b1));

      // lw x1,-4(x2)
      e = vi(ALL & ~(16'h1 << F_RS2), 32'h30, 5'd1, 4'd0, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b1);
      e.mre = 1'b1;
      run(32'hFFC12083, 32'h30, e);

      // sw x3,8(x2): x3 still holds the earlier writeback
      e = vi(ALL & ~(16'h1 << F_RD), 32'h34, 5'd0, 4'd0, 32'h8, 3'd2, 1'b1, 1'b0);
      e.mwe = 1'b1; e.rs2 = 32'hDEADBEEF;
      run(32'h00312423, 32'h34, e);

      // single redirect on the second of four ADDIs
      run(32'h00500093, 32'h40, addi_exp(32'h40));
      issue(1'b0, 32'h00500093, 32'h44, 1'b1, 1'b0, 5'd0, 32'h0, mk(ALL));
      run(32'h00500093, 32'h48, mk(ALL));
      run(32'h00500093, 32'h4C, addi_exp(32'h4C));

      // back-to-back redirects reload the window
      run(32'h00500093, 32'h50, addi_exp(32'h50));
      issue(1'b0, 32'h00500093, 32'h54, 1'b1, 1'b0, 5'd0, 32'h0, mk(ALL));
      issue(1'b0, 32'h00500093, 32'h58, 1'b1, 1'b0, 5'd0, 32'h0, mk(ALL));
      run(32'h00500093, 32'h5C, mk(ALL));
      run(32'h00500093, 32'h60, addi_exp(32'h60));

      // unknown opcode and OP with a bad funct7
      e = mk(CTL); e.valid = 1'b1; e.ill = 1'b1;
      run(32'hFFFFFFFF, 32'h64, e);
      run(32'h020000B3, 32'h68, e);

      // write to x0 alongside a bubble word, then read x0 twice
      issue(1'b0, 32'h0, 32'h6C, 1'b0, 1'b1, 5'd0, 32'h7, mk(ALL));
      e = vi(ALL & ~(16'h1 << F_IMM), 32'h70, 5'd5, 4'd0, 32'h0, 3'd0, 1'b0, 1'b1);
      issue(1'b0, 32'h000002B3, 32'h70, 1'b0, 1'b1, 5'd0, 32'h7, e);
      e.pc = 32'h74;
      run(32'h000002B3, 32'h74, e);

      @(negedge clk);
      bus.InstrD = 32'h0;
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
